// File: rtl/lcd_pkg.sv
// Shared state type, counter width and timing-window helpers for the LCD
// read-side timing generator.
package lcd_pkg;

   localparam int CNT_W   = 12;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // One axis of the raster: period plus the sync and active windows [lo, hi).
   typedef struct packed {
      logic [CNT_W-1:0] total;
      logic [CNT_W-1:0] sync_hi;
      logic [CNT_W-1:0] act_lo;
      logic [CNT_W-1:0] act_hi;
   } win_t;

   function automatic int axis_total(int sync_w, int bp, int act, int fp);
      return sync_w + bp + act + fp;
   endfunction

   function automatic win_t axis_win(int sync_w, int bp, int act, int fp);
      win_t w;
      w.total   = CNT_W'(axis_total(sync_w, bp, act, fp));
      w.sync_hi = CNT_W'(sync_w);
      w.act_lo  = CNT_W'(sync_w + bp);
      w.act_hi  = CNT_W'(sync_w + bp + act);
      return w;
   endfunction

endpackage

// File: rtl/lcd_timing_rd_if.sv
// Read-port bundle between the LCD timing reader (master) and the line FIFO
// (slave).
interface lcd_timing_rd_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  lcd_data_requst;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_empty;

   modport master (
      output lcd_data_requst,
      input  fifo_rd_data,
      input  fifo_empty
   );

   modport slave (
      input  lcd_data_requst,
      output fifo_rd_data,
      output fifo_empty
   );
endinterface

// File: rtl/lcd_sync_cnt.sv
// H/V raster counter pair with wrap logic and registered-counter window
// decodes; counters sit at zero whenever run is low.
module lcd_sync_cnt
   import lcd_pkg::*;
#(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 3,
   parameter int V_BP     = 21
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic hsync,
   output logic vsync,
   output logic pix_act,
   output logic frame_last
);

   localparam win_t H_WIN = axis_win(H_SYNC, H_BP, H_ACTIVE, H_FP);
   localparam win_t V_WIN = axis_win(V_SYNC, V_BP, V_ACTIVE, V_FP);

   if (axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP) > CNT_MAX) begin : g_h_range
      $error("H_TOTAL does not fit the 12-bit counter");
   end
   if (axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP) > CNT_MAX) begin : g_v_range
      $error("V_TOTAL does not fit the 12-bit counter");
   end

   logic [1:0] step;
   logic [1:0] last;
   logic [1:0] in_sync;
   logic [1:0] in_act;

   // Axis 0 is horizontal; axis 1 steps only when the line wraps.
   assign step = {run & last[0], run};

   for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      localparam win_t W = (gi == 0) ? H_WIN : V_WIN;

      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;

      assign last[gi] = (cnt_reg == W.total - CNT_W'(1));

      always_comb begin
         cnt_next = '0;
         if (run) begin
            cnt_next = cnt_reg;
            if (step[gi]) begin
               cnt_next = last[gi] ? '0 : cnt_reg + CNT_W'(1);
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_next;
         end
      end

      assign in_sync[gi] = (cnt_reg < W.sync_hi);
      assign in_act[gi]  = (cnt_reg >= W.act_lo) && (cnt_reg < W.act_hi);
   end

   assign hsync      = in_sync[0];
   assign vsync      = in_sync[1];
   assign pix_act    = &in_act;
   assign frame_last = &last;

endmodule

// File: rtl/lcd_timing_rd.sv
// Pixel-clock side of the LCD line FIFO: aligns to the writer's frame sync,
// generates HS/VS/DE, pulls pixels, and drains after an underflowed frame.
module lcd_timing_rd
   import lcd_pkg::*;
#(
   parameter int H_ACTIVE   = 800,
   parameter int H_FP       = 40,
   parameter int H_SYNC     = 128,
   parameter int H_BP       = 88,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 1,
   parameter int V_SYNC     = 3,
   parameter int V_BP       = 21,
   parameter int DATA_WIDTH = 16,
   parameter bit SYNC_POL   = 1'b0
) (
   input  logic                  lcd_clk,
   input  logic                  rst_n,
   input  logic                  lcd_framesync,
   lcd_timing_rd_if.master       fifo,
   output logic                  lcd_hs,
   output logic                  lcd_vs,
   output logic                  lcd_de,
   output logic [DATA_WIDTH-1:0] lcd_rgb,
   output logic                  underflow
);

   state_t state_reg, state_next;
   logic [1:0] fs_sync_reg;
   logic       fs_prev_reg;
   logic       frame_start;
   logic       frame_uf_reg, frame_uf_next;
   logic       underflow_reg;
   logic       run, hsync, vsync, pix_act, frame_last, miss;
   logic       s1_hs_reg, s1_vs_reg, s1_de_reg, s1_miss_reg;
   logic       hs_pin_reg, vs_pin_reg, de_pin_reg;
   logic [DATA_WIDTH-1:0] rgb_pin_reg;

   lcd_sync_cnt #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_cnt (
      .clk        (lcd_clk),
      .rst_n      (rst_n),
      .run        (run),
      .hsync      (hsync),
      .vsync      (vsync),
      .pix_act    (pix_act),
      .frame_last (frame_last)
   );

   assign frame_start = fs_sync_reg[1] & ~fs_prev_reg;
   assign run         = (state_reg == RUN);
   assign miss        = run & pix_act & fifo.fifo_empty;

   always_comb begin
      state_next           = state_reg;
      frame_uf_next        = frame_uf_reg | miss;
      fifo.lcd_data_requst = 1'b0;
      unique case (state_reg)
         WAIT: begin
            frame_uf_next = 1'b0;
            if (frame_start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            fifo.lcd_data_requst = pix_act & ~fifo.fifo_empty;
            if (frame_last) begin
               frame_uf_next = 1'b0;
               if (frame_uf_reg | miss) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Flush stale words so the next frame starts on a clean FIFO.
            fifo.lcd_data_requst = ~fifo.fifo_empty;
            if (fifo.fifo_empty) begin
               state_next = WAIT;
            end
         end
         default: state_next = WAIT;
      endcase
   end

   always_ff @(posedge lcd_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= WAIT;
         fs_sync_reg   <= '0;
         fs_prev_reg   <= 1'b0;
         frame_uf_reg  <= 1'b0;
         underflow_reg <= 1'b0;
         s1_hs_reg     <= 1'b0;
         s1_vs_reg     <= 1'b0;
         s1_de_reg     <= 1'b0;
         s1_miss_reg   <= 1'b0;
         hs_pin_reg    <= ~SYNC_POL;
         vs_pin_reg    <= ~SYNC_POL;
         de_pin_reg    <= 1'b0;
         rgb_pin_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         fs_sync_reg   <= {fs_sync_reg[0], lcd_framesync};
         fs_prev_reg   <= fs_sync_reg[1];
         frame_uf_reg  <= frame_uf_next;
         underflow_reg <= underflow_reg | miss;
         s1_hs_reg     <= run & hsync;
         s1_vs_reg     <= run & vsync;
         s1_de_reg     <= run & pix_act;
         s1_miss_reg   <= miss;
         hs_pin_reg    <= s1_hs_reg ? SYNC_POL : ~SYNC_POL;
         vs_pin_reg    <= s1_vs_reg ? SYNC_POL : ~SYNC_POL;
         // DE stays high on a missed pixel so panel timing is unaffected.
         de_pin_reg    <= s1_de_reg;
         rgb_pin_reg   <= (s1_de_reg & ~s1_miss_reg) ? fifo.fifo_rd_data : '0;
      end
   end

   assign lcd_hs    = hs_pin_reg;
   assign lcd_vs    = vs_pin_reg;
   assign lcd_de    = de_pin_reg;
   assign lcd_rgb   = rgb_pin_reg;
   assign underflow = underflow_reg;

endmodule

// File: tb/tb_lcd_timing_rd.sv
// Self-checking bench for lcd_timing_rd on a 7x5 raster, with a queue-based
// FIFO model and an arithmetic raster reference.
module tb_lcd_timing_rd;

   localparam int HT = 7;
   localparam int VT = 5;
   localparam int FT = HT * VT;

   logic        lcd_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lcd_framesync = 1'b0;
   logic        lcd_hs, lcd_vs, lcd_de, underflow;
   logic [15:0] lcd_rgb;

   logic [15:0] q[$];
   logic        fifo_empty_r = 1'b1;
   logic [15:0] rd_data_r = '0;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int n1;        // words preloaded before the frame
      int p2;        // words pushed late in the first frame
      int fs_low;    // cycle to drop framesync (-1 none)
      int fs_high;   // cycle to raise framesync again (-1 none)
      bit seq;       // 1..N data instead of random
      int exp_reqs;  // total read requests expected
      int exp_uf;    // underflow flag at the end
   } vec_t;

   lcd_timing_rd_if #(.DATA_WIDTH(16)) fif ();

   lcd_timing_rd #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .DATA_WIDTH(16), .SYNC_POL(1'b0)
   ) dut (
      .lcd_clk       (lcd_clk),
      .rst_n         (rst_n),
      .lcd_framesync (lcd_framesync),
      .fifo          (fif.master),
      .lcd_hs        (lcd_hs),
      .lcd_vs        (lcd_vs),
      .lcd_de        (lcd_de),
      .lcd_rgb       (lcd_rgb),
      .underflow     (underflow)
   );

   always #5 lcd_clk = ~lcd_clk;

   assign fif.fifo_empty   = fifo_empty_r;
   assign fif.fifo_rd_data = rd_data_r;

   always @(posedge lcd_clk) begin
      if (fif.lcd_data_requst && q.size() > 0) begin
         rd_data_r <= q[0];
         q.delete(0);
      end
      fifo_empty_r <= (q.size() == 0);
   end

   function automatic bit act_pos(int k);
      int h = k % HT;
      int v = (k / HT) % VT;
      return (h >= 2) && (h < 6) && (v >= 2) && (v < 4);
   endfunction

   function automatic int pix_idx(int k);
      return ((k / HT) % VT - 2) * 4 + (k % HT - 2);
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic check_idle(input string tag, input int exp_uf);
      chk({tag, " hs"}, int'(lcd_hs), 1);
      chk({tag, " vs"}, int'(lcd_vs), 1);
      chk({tag, " de"}, int'(lcd_de), 0);
      chk({tag, " rgb"}, int'(lcd_rgb), 0);
      chk({tag, " req"}, int'(fif.lcd_data_requst), 0);
      chk({tag, " uf"}, int'(underflow), exp_uf);
   endtask

   task automatic apply_reset();
      @(negedge lcd_clk);
      lcd_framesync = 1'b0;
      rst_n = 1'b0;
      q.delete();
      repeat (3) @(negedge lcd_clk);
      rst_n = 1'b1;
      repeat (3) @(negedge lcd_clk);
   endtask

   // Cycle n counts negedges after framesync rises: raster position n-2 drives
   // the request, position n-4 is on the pins.
   task automatic run_vec(input vec_t v, input int vi, input bit do_reset);
      logic [15:0] d[16];
      int nf, run_end, stale, miss_pos, reqs, nmax, kr, kp, lim, base, j;
      int e_req, e_hs, e_vs, e_de, e_rgb, e_uf;
      string tag;
      if (do_reset) apply_reset();
      for (int i = 0; i < 16; i++) begin
         d[i] = v.seq ? 16'(i + 1) : 16'($urandom_range(1, 65535));
      end
      for (int i = 0; i < v.n1; i++) q.push_back(d[i]);
      repeat (2) @(negedge lcd_clk);
      nf       = (v.n1 < 8) ? 1 : 2;
      run_end  = FT * nf;
      stale    = (v.n1 < 8) ? v.p2 : 0;
      miss_pos = -1;
      for (int k = 0; k < run_end; k++) begin
         lim = (k < FT) ? v.n1 : v.p2;
         if (miss_pos < 0 && act_pos(k) && pix_idx(k) >= lim) miss_pos = k;
      end
      reqs = 0;
      nmax = run_end + stale + 16;
      lcd_framesync = 1'b1;
      for (int n = 0; n <= nmax; n++) begin
         @(negedge lcd_clk);
         tag = $sformatf("v%0d n%0d", vi, n);
         kr = n - 2;
         kp = n - 4;
         if (kr >= 0 && kr < run_end) begin
            lim   = (kr < FT) ? v.n1 : v.p2;
            e_req = int'(act_pos(kr) && pix_idx(kr) < lim);
         end else begin
            e_req = int'(kr >= run_end && kr < run_end + stale);
         end
         if (kp >= 0 && kp < run_end) begin
            e_hs  = int'(kp % HT != 0);
            e_vs  = int'((kp / HT) % VT != 0);
            e_de  = int'(act_pos(kp));
            lim   = (kp < FT) ? v.n1 : v.p2;
            base  = (kp < FT) ? 0 : v.n1;
            j     = pix_idx(kp);
            e_rgb = (e_de != 0 && j < lim) ? int'(d[base + j]) : 0;
         end else begin
            e_hs = 1; e_vs = 1; e_de = 0; e_rgb = 0;
         end
         e_uf = int'(miss_pos >= 0 && n >= miss_pos + 3);
         chk({tag, " req"}, int'(fif.lcd_data_requst), e_req);
         chk({tag, " hs"}, int'(lcd_hs), e_hs);
         chk({tag, " vs"}, int'(lcd_vs), e_vs);
         chk({tag, " de"}, int'(lcd_de), e_de);
         chk({tag, " rgb"}, int'(lcd_rgb), e_rgb);
         chk({tag, " uf"}, int'(underflow), e_uf);
         if (fif.lcd_data_requst) reqs++;
         if (n == 31) begin
            for (int i = 0; i < v.p2; i++) q.push_back(d[v.n1 + i]);
         end
         if (n == v.fs_low)  lcd_framesync = 1'b0;
         if (n == v.fs_high) lcd_framesync = 1'b1;
      end
      chk($sformatf("v%0d total reqs", vi), reqs, v.exp_reqs);
      chk($sformatf("v%0d final uf", vi), int'(underflow), v.exp_uf);
      $display("vec %0d n1=%0d p2=%0d fs_low=%0d fs_high=%0d reqs=%0d uf=%0d",
               vi, v.n1, v.p2, v.fs_low, v.fs_high, reqs, underflow);
   endtask

   initial begin
      vec_t tbl[6];
      vec_t rv;
      int   re, st;

      tbl[0] = '{n1: 8, p2: 5, fs_low: -1, fs_high: -1, seq: 1, exp_reqs: 13, exp_uf: 1};
      tbl[1] = '{n1: 5, p2: 0, fs_low: -1, fs_high: -1, seq: 0, exp_reqs: 5,  exp_uf: 1};
      tbl[2] = '{n1: 3, p2: 3, fs_low: 5,  fs_high: 36, seq: 0, exp_reqs: 6,  exp_uf: 1};
      tbl[3] = '{n1: 3, p2: 3, fs_low: 5,  fs_high: 38, seq: 0, exp_reqs: 6,  exp_uf: 1};
      tbl[4] = '{n1: 8, p2: 4, fs_low: 5,  fs_high: 20, seq: 0, exp_reqs: 12, exp_uf: 1};
      tbl[5] = '{n1: 0, p2: 2, fs_low: -1, fs_high: -1, seq: 0, exp_reqs: 2,  exp_uf: 1};

      apply_reset();
      for (int c = 0; c < 100; c++) begin
         @(negedge lcd_clk);
         check_idle($sformatf("reset c%0d", c), 0);
      end
      $display("reset idle window of 100 cycles checked");

      for (int i = 0; i < 6; i++) run_vec(tbl[i], i, 1'b1);

      for (int i = 0; i < 6; i++) begin
         rv.n1      = int'($urandom_range(0, 8));
         rv.p2      = int'($urandom_range(0, 7));
         rv.seq     = 1'b0;
         re         = (rv.n1 < 8) ? FT : 2 * FT;
         st         = (rv.n1 < 8) ? rv.p2 : 0;
         rv.fs_low  = 5;
         rv.fs_high = int'($urandom_range(7, re + st));
         rv.exp_reqs = rv.n1 + rv.p2;
         rv.exp_uf   = 1;
         run_vec(rv, 10 + i, 1'b1);
      end

      // Reset pulse in the middle of an active line, after an underflow.
      apply_reset();
      q.push_back(16'h1234);
      q.push_back(16'h5678);
      repeat (2) @(negedge lcd_clk);
      lcd_framesync = 1'b1;
      repeat (22) @(negedge lcd_clk);
      chk("midrst pre de", int'(lcd_de), 1);
      chk("midrst pre uf", int'(underflow), 1);
      #2;
      rst_n = 1'b0;
      lcd_framesync = 1'b0;
      #1;
      check_idle("midrst async", 0);
      q.delete();
      repeat (3) @(negedge lcd_clk);
      rst_n = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge lcd_clk);
         check_idle($sformatf("midrst wait c%0d", c), 0);
      end
      $display("mid-line reset sequence checked");
      rv = '{n1: 8, p2: 3, fs_low: -1, fs_high: -1, seq: 0, exp_reqs: 11, exp_uf: 1};
      run_vec(rv, 99, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_timing_rd.md
Name: lcd_timing_rd

Overview:
- Pixel-clock-side consumer of the LCD line FIFO; the reading end of the frame-sync / data-request interface of the FIFO controller.
- Generates RGB-LCD timing (HS/VS/DE) and issues lcd_data_requst to pull pixels from the FIFO read port.
- Aligns scan-out to the writer's frame sync, detects FIFO underflow, and drains and re-aligns after a corrupted frame.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, HS pulse width
- H_BP, 88, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, VS pulse width (lines)
- V_BP, 21, vertical back porch
- DATA_WIDTH, 16, pixel width (RGB565)
- SYNC_POL, 0, active level of HS/VS

Ports:
- lcd_clk  input  1  pixel clock; same clock as the FIFO read clock
- rst_n  input  1  asynchronous active-low reset
- lcd_framesync  input  1  frame-sync level from the write-side controller (foreign domain)
- lcd_data_requst  output  1  FIFO read enable
- fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid 1 cycle after lcd_data_requst
- fifo_empty  input  1  FIFO empty flag
- lcd_hs  output  1  horizontal sync
- lcd_vs  output  1  vertical sync
- lcd_de  output  1  data enable
- lcd_rgb  output  DATA_WIDTH  pixel data
- underflow  output  1  sticky underflow flag

Behaviour:
- Totals:
  - H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP.
  - V_TOTAL is formed the same way from the vertical parameters.
  - Counters are 12-bit unsigned; elaboration fails if either total exceeds 4095.
- h_cnt counts 0..H_TOTAL-1, then wraps to 0 and advances v_cnt. v_cnt wraps at V_TOTAL-1.
- Per-line order: sync [0, H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), front porch. Vertical order is identical.
- lcd_framesync passes through a 2-flop synchronizer. A rising edge of the synchronized signal is a frame-start event.
- State machine:
  - WAIT (reset state): counters held at 0; HS/VS/DE inactive; no reads. On frame-start event, go to RUN; counters start at h=0, v=0 on the next cycle.
  - RUN: counters free-run. Frame-start events are ignored. At the final pixel (h=H_TOTAL-1, v=V_TOTAL-1):
    - if an underflow occurred in this frame, go to DRAIN;
    - otherwise stay in RUN and wrap.
  - DRAIN: counters held at 0; outputs blank. lcd_data_requst = ~fifo_empty. Go to WAIT on the first cycle fifo_empty=1.
- Read request (RUN only): pix_act = h and v both in their active windows (decoded from the registered counters). lcd_data_requst = pix_act & ~fifo_empty. No other logic on this path.
- Underflow:
  - When pix_act=1 and fifo_empty=1: no read is issued, that pixel is output as 0, and the frame-underflow bit is set.
  - The underflow output is set on the same event and stays set until reset.
- Output pipeline (all outputs registered, 2-cycle latency from counters):
  - Stage 1 registers hs/vs/de/missed.
  - Stage 2 drives the pins.
  - lcd_rgb = (de & ~missed) ? fifo_rd_data captured at stage 1 : 0.
  - lcd_de at pin = pix_act of 2 cycles earlier. This holds even on underflow, so the panel timing is preserved.
- Sync polarity: lcd_hs/lcd_vs are SYNC_POL during their sync windows and ~SYNC_POL otherwise.
- Reset values: lcd_hs=lcd_vs=~SYNC_POL; lcd_de=0; lcd_rgb=0; lcd_data_requst=0; underflow=0; state=WAIT; pipeline flops=0.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously). After release, the block waits for a new frame-start event.
- Simultaneous frame-start event and DRAIN exit: the event is lost. The block waits for the next rising edge.

Decomposition:
- Shared package lcd_pkg holds:
  - a state enum (WAIT, RUN, DRAIN);
  - the 12-bit counter width constant;
  - a function for timing totals and active-window bounds.
- One natural sub-module, lcd_sync_cnt: the H/V counter pair with wrap logic and the window decodes (hsync, vsync, pix_act, frame_last).

Test Plan:
- Small timing (H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1; H_TOTAL=7, V_TOTAL=5). Check reset: all outputs at reset values; no requests with framesync low over 100 cycles.
- Framesync rise with FIFO preloaded 0x0001..0x0008:
  - requests begin 2 cycles after the synchronizer edge plus the v/h offset;
  - lcd_de pulses 4 cycles on lines v=2 and v=3;
  - lcd_rgb shows 1..8 in order, with lcd_de aligned to data;
  - frame period is 35 cycles.
- Underflow: preload 5 words, then empty.
  - Pixels 6..8 are 0 with lcd_de still high, and underflow=1.
  - After the frame end, DRAIN, then WAIT; no HS pulses until the next framesync edge.
- DRAIN with 3 stale words: exactly 3 lcd_data_requst cycles, then WAIT. A framesync edge during DRAIN is ignored.
- Extra framesync toggle mid-RUN: timing is unaffected (counter continuity checked); no re-alignment.
- rst_n pulse mid-active-line: outputs go to reset values asynchronously; underflow clears; scan restarts only on a subsequent framesync edge.
